// File: rtl/serial_wb_master.sv
// Byte-stream command parser driving a Wishbone classic master.
// Frames: opcode, address, count (0 = 256), then write data; reads stream back on m_axis.
module serial_wb_master #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       sreset,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic [7:0] s_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tlast,
    output logic       wb_cyc,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [7:0] wb_adr,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack,
    output logic       timeout_err,
    output logic       busy,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_ADDR  = 3'd1,
        S_COUNT = 3'd2,
        S_WDATA = 3'd3,
        S_WB_WR = 3'd4,
        S_WB_RD = 3'd5,
        S_RDATA = 3'd6
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  rdat_q, rdat_d;
    logic [8:0]  rem_q, rem_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        s_fire;

    // Both streams: a byte moves on a rising edge where tvalid && tready are high;
    // the source holds tdata (and tlast) stable while tvalid is high and tready is low.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!sreset) begin
            case (state_q)
                S_OP, S_ADDR, S_COUNT, S_WDATA: s_axis_tready = 1'b1;
                default:                        s_axis_tready = 1'b0;
            endcase
        end
    end

    assign s_fire = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        is_wr_d = is_wr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        case (state_q)
            S_OP: begin
                if (s_fire && (s_axis_tdata == 8'h00 || s_axis_tdata == 8'h01)) begin
                    is_wr_d = s_axis_tdata[0];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (s_fire) begin
                    adr_d   = s_axis_tdata;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (s_fire) begin
                    rem_d   = (s_axis_tdata == 8'h00) ? 9'd256 : {1'b0, s_axis_tdata};
                    tmo_d   = 16'd0;
                    state_d = is_wr_q ? S_WDATA : S_WB_RD;
                end
            end
            S_WDATA: begin
                if (s_fire) begin
                    dat_d   = s_axis_tdata;
                    tmo_d   = 16'd0;
                    state_d = S_WB_WR;
                end
            end
            S_WB_WR: begin
                if (wb_ack) begin
                    rem_d   = rem_q - 9'd1;
                    state_d = (rem_q == 9'd1) ? S_OP : S_WDATA;
                end else if (tmo_q == TMO_LAST) begin
                    // Give up on the whole burst; leftover data bytes get parsed as opcodes.
                    err_d   = 1'b1;
                    state_d = S_OP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_WB_RD: begin
                if (wb_ack) begin
                    rdat_d  = wb_dat_i;
                    state_d = S_RDATA;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_OP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RDATA: begin
                if (m_axis_tready) begin
                    rem_d   = rem_q - 9'd1;
                    tmo_d   = 16'd0;
                    state_d = (rem_q == 9'd1) ? S_OP : S_WB_RD;
                end
            end
            default: state_d = S_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q <= S_OP;
            is_wr_q <= 1'b0;
            adr_q   <= 8'h00;
            dat_q   <= 8'h00;
            rdat_q  <= 8'h00;
            rem_q   <= 9'd0;
            tmo_q   <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign wb_cyc        = (state_q == S_WB_WR) || (state_q == S_WB_RD);
    assign wb_stb        = wb_cyc;
    assign wb_we         = (state_q == S_WB_WR);
    assign wb_adr        = adr_q;
    assign wb_dat_o      = dat_q;
    assign m_axis_tvalid = (state_q == S_RDATA);
    assign m_axis_tlast  = m_axis_tvalid && (rem_q == 9'd1);
    assign m_axis_tdata  = rdat_q;
    assign timeout_err   = err_q;
    assign busy          = (state_q != S_OP);
    assign dbg_state_o   = state_q;

endmodule
